// File: rtl/adc_snapshot_seq_if.sv
// adc_snapshot_seq_if: conversion handshake to the ADC front-end plus the
// raw-register write port driven by the snapshot sequencer.
interface adc_snapshot_seq_if #(
  parameter int DATA_W = 24
);
  logic              conv_req;
  logic [2:0]        conv_ch;
  logic              conv_ack;
  logic [DATA_W-1:0] conv_data;
  logic              raw_we;
  logic [2:0]        raw_ch;
  logic [31:0]       raw_data;

  modport master (
    output conv_req, conv_ch, raw_we, raw_ch, raw_data,
    input  conv_ack, conv_data
  );

  modport slave (
    input  conv_req, conv_ch, raw_we, raw_ch, raw_data,
    output conv_ack, conv_data
  );
endinterface

// File: rtl/adc_snapshot_seq.sv
// adc_snapshot_seq: converts each configured channel once per snapshot and writes
// the sign-extended samples to the raw registers. ADC_SNAPSHOT_PERIODIC_EN adds an auto-trigger timer.
module adc_snapshot_seq #(
  parameter int NUM_CH_MAX     = 8,
  parameter int DATA_W         = 24,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PERIOD_W       = 24
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable,
  input  logic                snap_req,
  input  logic [3:0]          num_ch,
  input  logic [PERIOD_W-1:0] period_cycles,
  adc_snapshot_seq_if.master  fe,
  output logic                busy,
  output logic                done_pulse,
  output logic                timeout_pulse
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, STORE, DONE} state_t;

  state_t        state;
  logic          pending;
  logic [3:0]    n;
  logic [2:0]    ch;
  logic [TW-1:0] tcnt;
  logic [3:0]    n_clamp;
  logic          trig;

  assign n_clamp = (num_ch > 4'(NUM_CH_MAX)) ? 4'(NUM_CH_MAX) : num_ch;

`ifdef ADC_SNAPSHOT_PERIODIC_EN
  logic [PERIOD_W-1:0] period_cnt;
  logic                auto_trig;

  // Reload with period-1 so a trigger fires exactly every period_cycles cycles.
  assign auto_trig = enable && (period_cycles != '0) && (period_cnt == '0);
  assign trig      = snap_req | auto_trig;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      period_cnt <= '0;
    end else if (state == IDLE && !enable) begin
      period_cnt <= period_cycles - PERIOD_W'(1);
    end else if (enable && period_cycles != '0) begin
      if (period_cnt == '0) period_cnt <= period_cycles - PERIOD_W'(1);
      else                  period_cnt <= period_cnt - PERIOD_W'(1);
    end
  end
`else
  logic unused_period;
  assign unused_period = ^period_cycles;
  assign trig          = snap_req;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      pending       <= 1'b0;
      n             <= '0;
      ch            <= '0;
      tcnt          <= '0;
      fe.conv_req   <= 1'b0;
      fe.conv_ch    <= '0;
      fe.raw_we     <= 1'b0;
      fe.raw_ch     <= '0;
      fe.raw_data   <= '0;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else if (state != IDLE && !enable) begin
      // Losing enable mid-snapshot abandons it silently, including any queued restart.
      state         <= IDLE;
      pending       <= 1'b0;
      fe.conv_req   <= 1'b0;
      fe.raw_we     <= 1'b0;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      if (state != IDLE && trig) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (enable && (trig || pending)) begin
            pending <= 1'b0;
            n       <= n_clamp;
            ch      <= '0;
            tcnt    <= '0;
            busy    <= 1'b1;
            if (n_clamp == 4'd0) begin
              state      <= DONE;
              done_pulse <= 1'b1;
            end else begin
              state       <= WAIT;
              fe.conv_req <= 1'b1;
              fe.conv_ch  <= '0;
            end
          end else if (!enable) begin
            pending <= 1'b0;
          end
        end
        WAIT: begin
          if (fe.conv_ack) begin
            fe.conv_req <= 1'b0;
            fe.raw_we   <= 1'b1;
            fe.raw_ch   <= ch;
            fe.raw_data <= {{(32-DATA_W){fe.conv_data[DATA_W-1]}}, fe.conv_data};
            state       <= STORE;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            fe.conv_req   <= 1'b0;
            timeout_pulse <= 1'b1;
            state         <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STORE: begin
          fe.raw_we <= 1'b0;
          if ({1'b0, ch} == n - 4'd1) begin
            state      <= DONE;
            done_pulse <= 1'b1;
          end else begin
            ch          <= ch + 3'd1;
            fe.conv_ch  <= ch + 3'd1;
            fe.conv_req <= 1'b1;
            tcnt        <= '0;
            state       <= WAIT;
          end
        end
        DONE: begin
          // A timeout enters here without done_pulse, so it follows one cycle later.
          if (!done_pulse) begin
            done_pulse    <= 1'b1;
            timeout_pulse <= 1'b0;
          end else begin
            done_pulse <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_snapshot_seq.sv
// tb_adc_snapshot_seq: randomized front-end and snapshot requests checked against a
// transaction-level model of which channels get written, with what data, and when.
module tb_adc_snapshot_seq;
  localparam int DATA_W = 24;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        snap_req;
  logic [3:0]  num_ch;
  logic [23:0] period_cycles;
  logic        busy;
  logic        done_pulse;
  logic        timeout_pulse;

  int checks = 0;
  int passes = 0;

  adc_snapshot_seq_if #(.DATA_W(DATA_W)) fe_if ();

  adc_snapshot_seq #(
    .NUM_CH_MAX(8), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .PERIOD_W(24)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .snap_req(snap_req),
    .num_ch(num_ch), .period_cycles(period_cycles), .fe(fe_if),
    .busy(busy), .done_pulse(done_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Front-end model configuration
  int          ack_delay = 3;
  bit   [7:0]  fe_never  = '0;
  bit          noise_en  = 1'b0;
  logic [23:0] fe_data [8];
  int          fe_cnt    = 0;

  // Observed transactions
  int          cyc = 0;
  logic [2:0]  wr_ch [$];
  logic [31:0] wr_data [$];
  int          done_q [$];
  int          rise_q [$];
  int          tmo_cnt = 0;
  int          tmo_cyc = 0;
  logic        tmo_req = 1'b0;
  logic        prev_req = 1'b0;

  // Acks after ack_delay request cycles; optional junk acks while no request is open.
  always @(negedge clk) begin
    if (fe_if.conv_req === 1'b1) begin
      fe_cnt++;
      if (!fe_never[fe_if.conv_ch] && fe_cnt >= ack_delay) begin
        fe_if.conv_ack  = 1'b1;
        fe_if.conv_data = fe_data[fe_if.conv_ch];
      end else begin
        fe_if.conv_ack  = 1'b0;
        fe_if.conv_data = 24'($urandom);
      end
    end else begin
      fe_cnt          = 0;
      fe_if.conv_ack  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      fe_if.conv_data = 24'($urandom);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (fe_if.raw_we === 1'b1) begin
      wr_ch.push_back(fe_if.raw_ch);
      wr_data.push_back(fe_if.raw_data);
    end
    if (done_pulse === 1'b1) done_q.push_back(cyc);
    if (timeout_pulse === 1'b1) begin
      tmo_cnt++;
      tmo_cyc = cyc;
      tmo_req = fe_if.conv_req;
    end
    if (fe_if.conv_req === 1'b1 && prev_req !== 1'b1) rise_q.push_back(cyc);
    prev_req = fe_if.conv_req;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clearMon();
    wr_ch.delete();
    wr_data.delete();
    done_q.delete();
    rise_q.delete();
    tmo_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] nch);
    num_ch   = nch;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int b = budget;
    while (done_q.size() < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    checkOutput(tag, done_q.size(), target);
  endtask

  function automatic int expN(input int nch);
    return (nch > 8) ? 8 : nch;
  endfunction

  function automatic logic [31:0] sextModel(input logic [23:0] d);
    int v = int'(d);
    if (v >= (1 << 23)) v = v - (1 << 24);
    return 32'(v);
  endfunction

  task automatic expectWrites(input int n, input int reps, input string tag);
    checkOutput({tag, "_count"}, wr_ch.size(), n * reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < n; i++) begin
        int idx = r * n + i;
        if (idx < wr_ch.size()) begin
          checkOutput({tag, "_ch"}, 32'(wr_ch[idx]), i);
          checkOutput({tag, "_data"}, wr_data[idx], sextModel(fe_data[i]));
        end
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    rst = 1'b1; enable = 1'b0; snap_req = 1'b0; num_ch = '0; period_cycles = '0;
    for (int i = 0; i < 8; i++) fe_data[i] = 24'($urandom);
    repeat (3) @(negedge clk);
    checkOutput("reset_ctl", {busy, done_pulse, timeout_pulse, fe_if.conv_req, fe_if.raw_we,
                fe_if.conv_ch, fe_if.raw_ch}, 0);
    checkOutput("reset_raw_data", fe_if.raw_data, 0);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    clearMon();

    // Basic four-channel sweep
    for (int i = 0; i < 8; i++) fe_data[i] = 24'(32'h100 + i);
    ack_delay = 3;
    applyStimulus(4'd4);
    checkOutput("start_latency", {fe_if.conv_req, fe_if.conv_ch}, {1'b1, 3'd0});
    waitDone(1, 200, "sweep_done");
    @(negedge clk);
    checkOutput("sweep_busy_low", busy, 0);
    expectWrites(4, 1, "sweep");
    checkOutput("sweep_reqs", rise_q.size(), 4);

    // Sign extension
    clearMon();
    fe_data[0] = 24'h800001;
    applyStimulus(4'd1);
    waitDone(1, 100, "sext_done");
    got = (wr_data.size() > 0) ? wr_data[0] : 32'hxxxxxxxx;
    checkOutput("sext_value", got, 32'hFF800001);

    // Timeout on channel 1
    clearMon();
    fe_data[0] = 24'($urandom);
    fe_never[1] = 1'b1;
    applyStimulus(4'd2);
    waitDone(1, 200, "tmo_done");
    @(negedge clk);
    expectWrites(1, 1, "tmo_write");
    checkOutput("tmo_pulses", tmo_cnt, 1);
    checkOutput("tmo_reqs", rise_q.size(), 2);
    if (rise_q.size() == 2 && done_q.size() == 1) begin
      checkOutput("tmo_latency", tmo_cyc - rise_q[1], TMO);
      checkOutput("tmo_done_next", done_q[0] - tmo_cyc, 1);
    end
    checkOutput("tmo_req_low", tmo_req, 0);
    fe_never[1] = 1'b0;

    // Coalescing of requests while busy
    clearMon();
    for (int i = 0; i < 8; i++) fe_data[i] = 24'($urandom);
    applyStimulus(4'd2);
    for (int k = 0; k < 3; k++) begin
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      @(negedge clk);
    end
    waitDone(2, 300, "coal_done");
    repeat (20) @(negedge clk);
    checkOutput("coal_no_third", done_q.size(), 2);
    expectWrites(2, 2, "coal");
    if (rise_q.size() >= 3 && done_q.size() >= 1)
      checkOutput("coal_restart", rise_q[2] - done_q[0], 2);

    // Request landing in the done cycle starts another snapshot
    clearMon();
    applyStimulus(4'd1);
    waitDone(1, 100, "donecyc_first");
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    waitDone(2, 100, "donecyc_second");
    checkOutput("donecyc_reqs", rise_q.size(), 2);

    // Abort on enable drop while waiting on channel 1, with a pending request
    clearMon();
    fe_never[1] = 1'b1;
    applyStimulus(4'd4);
    for (int b = 0; b < 50 && !(fe_if.conv_req === 1'b1 && fe_if.conv_ch == 3'd1); b++)
      @(negedge clk);
    checkOutput("abort_reached_ch1", {fe_if.conv_req, fe_if.conv_ch}, {1'b1, 3'd1});
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("abort_req_low", {fe_if.conv_req, busy}, 0);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("abort_writes", wr_ch.size(), 1);
    checkOutput("abort_no_done", done_q.size(), 0);
    checkOutput("abort_no_restart", rise_q.size(), 2);
    fe_never[1] = 1'b0;

    // Request while disabled is dropped
    clearMon();
    enable = 1'b0;
    applyStimulus(4'd3);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("disabled_drop", rise_q.size() + done_q.size(), 0);

    // Clamp of oversize channel count, then zero channels
    clearMon();
    ack_delay = 1;
    applyStimulus(4'd15);
    waitDone(1, 400, "clamp_done");
    @(negedge clk);
    expectWrites(8, 1, "clamp");
    clearMon();
    applyStimulus(4'd0);
    waitDone(1, 20, "zero_done");
    repeat (3) @(negedge clk);
    checkOutput("zero_no_req", rise_q.size() + wr_ch.size(), 0);

    // Randomized snapshots with junk acks and num_ch changed mid-flight
    noise_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int nch;
      clearMon();
      nch = $urandom_range(0, 15);
      ack_delay = $urandom_range(1, 5);
      for (int i = 0; i < 8; i++) fe_data[i] = 24'($urandom);
      applyStimulus(4'(nch));
      num_ch = 4'($urandom);
      waitDone(1, 500, "rnd_done");
      @(negedge clk);
      checkOutput("rnd_busy_low", busy, 0);
      expectWrites(expN(nch), 1, "rnd");
    end
    noise_en = 1'b0;

`ifdef ADC_SNAPSHOT_PERIODIC_EN
    clearMon();
    enable = 1'b0;
    num_ch = 4'd1;
    ack_delay = 1;
    period_cycles = 24'd100;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (450) @(negedge clk);
    checkOutput("periodic_count", done_q.size(), 4);
    for (int i = 1; i < done_q.size(); i++)
      checkOutput("periodic_interval", done_q[i] - done_q[i-1], 100);
    period_cycles = 24'd0;
    repeat (20) @(negedge clk);
    clearMon();
    repeat (300) @(negedge clk);
    checkOutput("periodic_off", done_q.size(), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/adc_snapshot_seq.md
Name: adc_snapshot_seq

Overview:
- Sequences one ADC snapshot across the configured channel count.
- Started by the ADC_CMD.SNAPSHOT pulse, gated by CTRL.ENABLE.
- Issues one conversion request per channel to the ADC front-end over a req/ack handshake and writes each result into the ADC_RAW_CHn registers of the Wishbone register block.
- Reports busy, done and timeout to the register/IRQ logic.

Parameters:
- NUM_CH_MAX, 8, maximum channels; num_ch is clamped to this value.
- DATA_W, 24, front-end sample width (two's complement).
- TIMEOUT_CYCLES, 1024, cycles to wait for conv_ack before aborting.
- PERIOD_W, 24, width of the periodic-trigger period (optional feature only).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- enable  in  1  CTRL.ENABLE level
- snap_req  in  1  one-cycle snapshot request (ADC_CMD.SNAPSHOT)
- num_ch  in  4  ADC_CFG.NUM_CH
- period_cycles  in  PERIOD_W  auto-trigger period; ignored unless the optional feature is built
- conv_req  out  1  conversion request to front-end
- conv_ch  out  3  channel of the current request
- conv_ack  in  1  front-end accepts and returns a sample
- conv_data  in  DATA_W  sample, valid while conv_ack=1
- raw_we  out  1  one-cycle write strobe to ADC_RAW regs
- raw_ch  out  3  target channel for raw_we
- raw_data  out  32  conv_data sign-extended to 32 bits
- busy  out  1  snapshot in progress
- done_pulse  out  1  one cycle at snapshot completion
- timeout_pulse  out  1  one cycle when a conversion times out

Behaviour:
- Reset (wb_rst_i=1 at a posedge):
  - State IDLE; all outputs 0.
  - Pending flag, channel index and timeout counter cleared.
- All outputs are registered.
- States: IDLE, WAIT, STORE, DONE.
- IDLE:
  - On enable=1 and (snap_req=1 or pending=1), latch n = min(num_ch, NUM_CH_MAX).
  - If n=0: go to DONE.
  - Otherwise: ch=0, go to WAIT; conv_req=1 and conv_ch=0 from the next cycle.
  - Latency: snap_req sampled at edge t0 gives conv_req=1 after t0.
  - snap_req with enable=0 is dropped.
- WAIT:
  - conv_req is held high.
  - When conv_ack=1 is sampled: capture conv_data, drop conv_req, go to STORE.
  - The timeout counter increments each WAIT cycle and is reset on entry.
  - At TIMEOUT_CYCLES: drop conv_req, pulse timeout_pulse, skip the raw write, go to DONE. The snapshot is aborted and the remaining channels are not converted.
- STORE:
  - raw_we=1 for one cycle with raw_ch=ch and raw_data={{(32-DATA_W){d[DATA_W-1]}},d}.
  - If ch=n-1, go to DONE; else ch+1 and WAIT.
  - Each channel costs 1 request cycle minimum + 1 store cycle.
- DONE: done_pulse=1 for one cycle (also after a timeout); go to IDLE.
- busy = 1 in WAIT, STORE and DONE.
- conv_ack outside WAIT is ignored.
- snap_req while busy sets pending. Multiple requests coalesce into one. Pending is serviced on return to IDLE, so the restart begins one cycle after done_pulse.
- enable falling while busy:
  - Abort at the next edge to IDLE.
  - conv_req=0; no raw_we, no done_pulse.
  - Pending cleared.
  - Already-written channels keep their values.
- num_ch changes mid-snapshot have no effect; n is latched at start.
- snap_req and the final done in the same cycle: treated as pending, and a new snapshot starts.

Optional Feature:
- ADC_SNAPSHOT_PERIODIC_EN defined:
  - Adds a PERIOD_W free-running down-counter, loaded with period_cycles while IDLE and enable=0.
  - With enable=1 and period_cycles≠0, counter underflow generates an internal snap_req (OR'd with the port) and reloads.
  - period_cycles=0 disables auto-trigger.
  - The counter keeps running while busy; a trigger while busy sets pending.
- Not defined: no counter; period_cycles unused; snapshots only from snap_req.

Test Plan:
- Basic sweep:
  - Stimulus: enable=1, num_ch=4, snap_req pulse; front-end acks 3 cycles after each req with data 0x000100+ch.
  - Required: raw_we ×4 with ch 0..3 and data 0x00000100..0x00000103; one done_pulse; busy low after it.
- Sign extension: conv_data=24'h800001 → raw_data=32'hFF800001.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, num_ch=2; ch0 acked, ch1 never acked.
  - Required: one raw_we (ch0); timeout_pulse 16 cycles after ch1 req; done_pulse next cycle; conv_req low.
- Coalescing: three snap_req pulses during a 2-channel snapshot → exactly one more snapshot (4 raw_we total, 2 done_pulse).
- Abort and clamp:
  - enable dropped while in WAIT on ch1 → conv_req low next cycle; no further raw_we; no done_pulse.
  - num_ch=15 → 8 conversions.
  - num_ch=0 → done_pulse with no conv_req.
- Periodic (with macro): period_cycles=100, num_ch=1, ack immediate → done_pulse every 100 cycles; period_cycles=0 → none.
